chnl_tx_arb: RTL and testbench

- Round-robin arbiter that shares one buffered CHNL transmitter among N independent producer streams.
- Each grant emits one fixed-length record: PAYLOAD data beats from a single source, then one trailer beat carrying source id, per-source sequence number and valid-beat count.
- Records are never interleaved, so the host can demultiplex fixed-size records.
- Sits between the producers and the transmitter's i_val/i_rdy/i_data input.

---
 rtl/chnl_tx_arb.sv | 162 ++++++++++++++++
 tb/tb_chnl_tx_arb.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chnl_tx_arb.sv
// Round-robin arbiter that shares one CHNL transmitter among N producer streams.
// Each grant emits PAYLOAD data beats from one source followed by a trailer beat.
module chnl_tx_arb #(
    parameter int N         = 4,
    parameter int TX_WIDTH  = 32,
    parameter int PAYLOAD   = 7,
    parameter int MAX_STALL = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            s_val,
    output logic [N-1:0]            s_rdy,
    input  logic [N*TX_WIDTH-1:0]   s_data,
    output logic                    o_val,
    input  logic                    o_rdy,
    output logic [TX_WIDTH-1:0]     o_data,
    output logic [3:0]              o_grant,
    output logic                    o_busy,
    output logic [15:0]             pad_cnt
);

    localparam int IW         = (N > 1) ? $clog2(N) : 1;
    localparam int SW         = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
    localparam int STALL_LAST = (MAX_STALL > 0) ? MAX_STALL - 1 : 0;

    localparam logic [1:0] S_ARB   = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_PAD   = 2'd2;
    localparam logic [1:0] S_TRAIL = 2'd3;

    logic [1:0]          state_reg;
    logic [IW-1:0]       g_reg;
    logic [IW-1:0]       last_reg;
    logic [7:0]          beat_cnt_reg;
    logic [7:0]          vcnt_reg;
    logic [SW-1:0]       stall_cnt_reg;
    logic [15:0]         pad_cnt_reg;
    logic [7:0]          seq_reg [N];
    logic [TX_WIDTH-1:0] src_data [N];

    logic                arb_hit;
    logic [IW-1:0]       arb_idx;
    logic [IW-1:0]       cand;
    logic                xfer;
    logic                last_beat;
    logic                trail_done;
    logic [31:0]         trail_word;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_src
            assign src_data[gi] = s_data[gi*TX_WIDTH +: TX_WIDTH];
            // Zero-latency ready pass-through, only for the source owning the record
            assign s_rdy[gi]    = (state_reg == S_DATA) && (g_reg == IW'(gi)) && o_rdy;
        end
    endgenerate

    // Descending scan so the nearest requester after the last grant wins
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = last_reg;
        cand    = '0;
        for (int i = N; i >= 1; i--) begin
            cand = IW'((int'(last_reg) + i) % N);
            if (s_val[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    assign trail_word = {8'hA5, seq_reg[g_reg], vcnt_reg, 4'h0, 4'(g_reg)};

    always_comb begin
        o_val  = 1'b0;
        o_data = '0;
        case (state_reg)
            S_DATA: begin
                o_val  = s_val[g_reg];
                o_data = src_data[g_reg];
            end
            S_PAD: o_val = 1'b1;
            S_TRAIL: begin
                o_val  = 1'b1;
                o_data = TX_WIDTH'(trail_word);
            end
            default: ;
        endcase
    end

    assign xfer       = o_val && o_rdy;
    assign last_beat  = (beat_cnt_reg == 8'(PAYLOAD - 1));
    assign trail_done = (state_reg == S_TRAIL) && xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_ARB;
            g_reg         <= '0;
            last_reg      <= IW'(N - 1);
            beat_cnt_reg  <= '0;
            vcnt_reg      <= '0;
            stall_cnt_reg <= '0;
            pad_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                S_ARB: begin
                    if (arb_hit) begin
                        g_reg         <= arb_idx;
                        beat_cnt_reg  <= '0;
                        vcnt_reg      <= '0;
                        stall_cnt_reg <= '0;
                        state_reg     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        beat_cnt_reg  <= beat_cnt_reg + 8'd1;
                        vcnt_reg      <= vcnt_reg + 8'd1;
                        stall_cnt_reg <= '0;
                        if (last_beat)
                            state_reg <= S_TRAIL;
                    end else if (!s_val[g_reg]) begin
                        // Back-pressure with valid data never reaches here
                        if (stall_cnt_reg != '1)
                            stall_cnt_reg <= stall_cnt_reg + 1'b1;
                        if (MAX_STALL != 0 && stall_cnt_reg == SW'(STALL_LAST))
                            state_reg <= S_PAD;
                    end
                end
                S_PAD: begin
                    if (xfer) begin
                        beat_cnt_reg <= beat_cnt_reg + 8'd1;
                        if (pad_cnt_reg != 16'hFFFF)
                            pad_cnt_reg <= pad_cnt_reg + 16'd1;
                        if (last_beat)
                            state_reg <= S_TRAIL;
                    end
                end
                default: begin
                    if (xfer) begin
                        last_reg  <= g_reg;
                        state_reg <= S_ARB;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++)
                seq_reg[k] <= '0;
        end else if (trail_done) begin
            seq_reg[g_reg] <= seq_reg[g_reg] + 8'd1;
        end
    end

    assign o_grant = 4'(last_reg);
    assign o_busy  = (state_reg != S_ARB);
    assign pad_cnt = pad_cnt_reg;

endmodule

// File: tb/tb_chnl_tx_arb.sv
// Directed bench for chnl_tx_arb: per-source producer models feed the arbiter and
// every output beat is captured with its cycle number for checking.
module tb_chnl_tx_arb;

    localparam int N         = 4;
    localparam int W         = 32;
    localparam int PAYLOAD   = 7;
    localparam int MAX_STALL = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     s_val;
    logic [N-1:0]     s_rdy;
    logic [N*W-1:0]   s_data;
    logic             o_val;
    logic             o_rdy;
    logic [W-1:0]     o_data;
    logic [3:0]       o_grant;
    logic             o_busy;
    logic [15:0]      pad_cnt;

    int               n_cmp = 0;
    int               n_err = 0;
    int               cyc = 0;
    int               prod_left [N];
    logic [31:0]      prod_next [N];
    bit               rdy_rand;
    bit               rdy_low;
    logic [31:0]      out_q [$];
    int               out_t [$];
    int               onehot_err;
    int               hold_err;
    bit               prev_stall;
    logic [31:0]      prev_data;

    always #5 clk = ~clk;

    chnl_tx_arb #(
        .N(N), .TX_WIDTH(W), .PAYLOAD(PAYLOAD), .MAX_STALL(MAX_STALL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_val(s_val), .s_rdy(s_rdy), .s_data(s_data),
        .o_val(o_val), .o_rdy(o_rdy), .o_data(o_data),
        .o_grant(o_grant), .o_busy(o_busy), .pad_cnt(pad_cnt)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of run, want finish before 1000000");
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive producers at negedge, sample just after, retire accepted beats
    task automatic cycle();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < N; k++) begin
            s_val[k]          = (prod_left[k] != 0);
            s_data[k*W +: W]  = prod_next[k];
        end
        o_rdy = rdy_low ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        #1;
        if (o_val && o_rdy) begin
            out_q.push_back(o_data);
            out_t.push_back(cyc);
        end
        if ($countones(s_rdy) > 1) onehot_err++;
        if (prev_stall && (!o_val || o_data !== prev_data)) hold_err++;
        prev_stall = o_val && !o_rdy;
        prev_data  = o_data;
        for (int k = 0; k < N; k++) begin
            if (s_rdy[k] && s_val[k]) begin
                prod_left[k]--;
                prod_next[k]++;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_val = '0; s_data = '0; o_rdy = 1'b0;
        rdy_rand = 1'b0; rdy_low = 1'b0;
        for (int k = 0; k < N; k++) begin
            prod_left[k] = 0;
            prod_next[k] = '0;
        end
        out_q.delete(); out_t.delete();
        onehot_err = 0; hold_err = 0; prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_val = '1; s_data = '1; o_rdy = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (o_val !== 1'b0) begin n_err++; $display("FAIL reset_o_val: got %b want 0", o_val); end
        n_cmp++; if (s_rdy !== 4'b0000) begin n_err++; $display("FAIL reset_s_rdy: got %b want 0000", s_rdy); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_o_busy: got %b want 0", o_busy); end
        s_val = '0;
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (o_grant !== 4'd3) begin n_err++; $display("FAIL reset_o_grant: got %0d want 3", o_grant); end
        n_cmp++; if (pad_cnt !== 16'd0) begin n_err++; $display("FAIL reset_pad_cnt: got %0d want 0", pad_cnt); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", o_busy); end
        $display("test_reset: o_grant=%0d pad_cnt=%0d", o_grant, pad_cnt);
    endtask

    task automatic test_single_record();
        int lim;
        logic [31:0] exp;
        do_reset();
        prod_left[0] = 14; prod_next[0] = 32'h11;
        lim = cyc + 100;
        while (out_q.size() < 16 && cyc < lim) cycle();
        n_cmp++; if (out_q.size() != 16) begin n_err++; $display("FAIL single_len: got %0d beats want 16", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 16; i++) begin
            if (i < 7)       exp = 32'h11 + 32'(i);
            else if (i == 7) exp = 32'hA500_0700;
            else if (i < 15) exp = 32'h18 + 32'(i - 8);
            else             exp = 32'hA501_0700;
            n_cmp++;
            if (out_q[i] !== exp) begin n_err++; $display("FAIL single_beat%0d: got %h want %h", i, out_q[i], exp); end
            else $display("single beat %0d: %h", i, out_q[i]);
        end
        cycle();
        n_cmp++; if (o_grant !== 4'd0) begin n_err++; $display("FAIL single_o_grant: got %0d want 0", o_grant); end
    endtask

    task automatic test_round_robin();
        int lim;
        int src;
        int occ;
        logic [31:0] exp;
        do_reset();
        for (int k = 0; k < N; k++) begin
            prod_left[k] = 100;
            prod_next[k] = 32'(k + 1) << 8;
        end
        lim = cyc + 200;
        while (out_q.size() < 40 && cyc < lim) cycle();
        n_cmp++; if (out_q.size() != 40) begin n_err++; $display("FAIL rr_len: got %0d beats want 40", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 40; i++) begin
            src = (i / 8) % 4;
            occ = (i / 8) / 4;
            if (i % 8 == 7) exp = {8'hA5, 8'(occ), 8'h07, 4'h0, 4'(src)};
            else            exp = (32'(src + 1) << 8) + 32'(occ * 7 + i % 8);
            n_cmp++;
            if (out_q[i] !== exp) begin n_err++; $display("FAIL rr_beat%0d: got %h want %h", i, out_q[i], exp); end
            else if (i % 8 == 7) $display("rr record %0d: src %0d trailer %h", i / 8, src, out_q[i]);
        end
        if (out_q.size() == 40) begin
            n_cmp++; if (out_t[15] - out_t[7] != 9) begin n_err++; $display("FAIL rr_period: got %0d cycles want 9", out_t[15] - out_t[7]); end
            n_cmp++; if (out_t[39] - out_t[31] != 9) begin n_err++; $display("FAIL rr_period_wrap: got %0d cycles want 9", out_t[39] - out_t[31]); end
        end
        n_cmp++; if (onehot_err != 0) begin n_err++; $display("FAIL rr_onehot: got %0d bad cycles want 0", onehot_err); end
    endtask

    task automatic test_backpressure();
        int lim;
        logic [31:0] exp;
        do_reset();
        prod_left[3] = 7; prod_next[3] = 32'h30;
        rdy_low = 1'b1;
        repeat (100) cycle();
        n_cmp++; if (out_q.size() != 0) begin n_err++; $display("FAIL bp_blocked: got %0d beats want 0", out_q.size()); end
        n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL bp_busy: got %b want 1", o_busy); end
        rdy_low = 1'b0; rdy_rand = 1'b1;
        lim = cyc + 500;
        while (out_q.size() < 8 && cyc < lim) cycle();
        n_cmp++; if (out_q.size() != 8) begin n_err++; $display("FAIL bp_len: got %0d beats want 8", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 8; i++) begin
            exp = (i == 7) ? 32'hA500_0703 : 32'h30 + 32'(i);
            n_cmp++;
            if (out_q[i] !== exp) begin n_err++; $display("FAIL bp_beat%0d: got %h want %h", i, out_q[i], exp); end
        end
        n_cmp++; if (hold_err != 0) begin n_err++; $display("FAIL bp_hold: got %0d changes want 0", hold_err); end
        n_cmp++; if (pad_cnt !== 16'd0) begin n_err++; $display("FAIL bp_pad_cnt: got %0d want 0", pad_cnt); end
        n_cmp++; if (prod_left[3] != 0) begin n_err++; $display("FAIL bp_accepted: got %0d left want 0", prod_left[3]); end
        $display("backpressure record done at cycle %0d", cyc);
    endtask

    task automatic test_padding();
        int lim;
        bit late;
        logic [31:0] exp;
        do_reset();
        prod_left[2] = 3; prod_next[2] = 32'h50;
        late = 1'b0;
        lim = cyc + 300;
        while (out_q.size() < 8 && cyc < lim) begin
            cycle();
            if (out_q.size() == 4 && !late) begin
                prod_left[2] = 5; prod_next[2] = 32'hDEAD_0000; late = 1'b1;
            end
        end
        n_cmp++; if (out_q.size() != 8) begin n_err++; $display("FAIL pad_len: got %0d beats want 8", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 8; i++) begin
            if (i < 3)       exp = 32'h50 + 32'(i);
            else if (i < 7)  exp = 32'h0;
            else             exp = 32'hA500_0302;
            n_cmp++;
            if (out_q[i] !== exp) begin n_err++; $display("FAIL pad_beat%0d: got %h want %h", i, out_q[i], exp); end
        end
        if (out_q.size() >= 4) begin
            n_cmp++; if (out_t[3] - out_t[2] != 65) begin n_err++; $display("FAIL pad_delay: got %0d cycles want 65", out_t[3] - out_t[2]); end
        end
        n_cmp++; if (pad_cnt !== 16'd4) begin n_err++; $display("FAIL pad_cnt: got %0d want 4", pad_cnt); end
        n_cmp++; if (prod_left[2] != 5) begin n_err++; $display("FAIL pad_late_accept: got %0d left want 5", prod_left[2]); end
        cycle();
        n_cmp++; if (o_grant !== 4'd2) begin n_err++; $display("FAIL pad_o_grant: got %0d want 2", o_grant); end
        $display("padding record trailer %h pad_cnt %0d", (out_q.size() == 8) ? out_q[7] : 32'h0, pad_cnt);
    endtask

    task automatic test_seq_wrap();
        int lim;
        do_reset();
        prod_left[1] = 257 * PAYLOAD; prod_next[1] = 32'h0;
        lim = cyc + 3000;
        while (out_q.size() < 257 * 8 && cyc < lim) cycle();
        n_cmp++; if (out_q.size() != 257 * 8) begin n_err++; $display("FAIL wrap_len: got %0d beats want %0d", out_q.size(), 257 * 8); end
        if (out_q.size() == 257 * 8) begin
            n_cmp++; if (out_q[7] !== 32'hA500_0701) begin n_err++; $display("FAIL wrap_first: got %h want a5000701", out_q[7]); end
            n_cmp++; if (out_q[255*8+7] !== 32'hA5FF_0701) begin n_err++; $display("FAIL wrap_256th: got %h want a5ff0701", out_q[255*8+7]); end
            n_cmp++; if (out_q[256*8+7] !== 32'hA500_0701) begin n_err++; $display("FAIL wrap_257th: got %h want a5000701", out_q[256*8+7]); end
            $display("seq wrap: 256th %h 257th %h", out_q[255*8+7], out_q[256*8+7]);
        end
        n_cmp++; if (pad_cnt !== 16'd0) begin n_err++; $display("FAIL wrap_pad_cnt: got %0d want 0", pad_cnt); end
    endtask

    task automatic test_reset_mid();
        int lim;
        logic [31:0] exp;
        do_reset();
        prod_left[0] = 20; prod_next[0] = 32'h70;
        lim = cyc + 100;
        while (out_q.size() < 11 && cyc < lim) cycle();
        n_cmp++; if (out_q.size() != 11) begin n_err++; $display("FAIL rmid_setup: got %0d beats want 11", out_q.size()); end
        @(negedge clk);
        s_val = 4'b0001; s_data[31:0] = prod_next[0]; o_rdy = 1'b1;
        #1;
        n_cmp++; if (o_val !== 1'b1) begin n_err++; $display("FAIL rmid_pre_val: got %b want 1", o_val); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (o_val !== 1'b0) begin n_err++; $display("FAIL rmid_o_val: got %b want 0", o_val); end
        n_cmp++; if (s_rdy !== 4'b0000) begin n_err++; $display("FAIL rmid_s_rdy: got %b want 0000", s_rdy); end
        do_reset();
        prod_left[0] = 20; prod_next[0] = 32'h80;
        prod_left[1] = 20; prod_next[1] = 32'h90;
        lim = cyc + 100;
        while (out_q.size() < 8 && cyc < lim) cycle();
        n_cmp++; if (out_q.size() != 8) begin n_err++; $display("FAIL rmid_len: got %0d beats want 8", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 8; i++) begin
            exp = (i == 7) ? 32'hA500_0700 : 32'h80 + 32'(i);
            n_cmp++;
            if (out_q[i] !== exp) begin n_err++; $display("FAIL rmid_beat%0d: got %h want %h", i, out_q[i], exp); end
        end
        $display("reset mid-record: restart trailer %h", (out_q.size() == 8) ? out_q[7] : 32'h0);
    endtask

    initial begin
        s_val = '0; s_data = '0; o_rdy = 1'b0;
        rdy_rand = 1'b0; rdy_low = 1'b0;
        prev_stall = 1'b0; prev_data = '0;
        onehot_err = 0; hold_err = 0;
        for (int k = 0; k < N; k++) begin
            prod_left[k] = 0;
            prod_next[k] = '0;
        end
        test_reset();
        test_single_record();
        test_round_robin();
        test_backpressure();
        test_padding();
        test_seq_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
